// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and issues the write-enable and request strobes for PC, IR, RF and data memory.
module mips_mc_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       PC_WE,
    output logic       IR_WE,
    output logic       RF_WE,
    output logic       MEM_RE,
    output logic       MEM_WE,
    output logic [1:0] PC_sel,
    output logic [1:0] ALU_Bin_sel,
    output logic [3:0] ALU_func,
    output logic       RF_WrData_sel,
    output logic       RF_Dst_sel,
    output logic       Fault,
    output logic [3:0] State
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_IFETCH   = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] BSEL_REG  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;

    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_JUMP   = 2'd2;

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic               funct_ok;
    logic [3:0]         r_func;
    logic               mem_phase;
    logic               timeout;

    // R-type function decode, shared by EXEC_R and R_WB
    always_comb begin
        funct_ok = 1'b1;
        r_func   = ALU_ADD;
        case (Funct)
            6'b100000: r_func = ALU_ADD;
            6'b100010: r_func = ALU_SUB;
            6'b100100: r_func = ALU_AND;
            6'b100101: r_func = ALU_OR;
            6'b101010: r_func = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    assign mem_phase = (state == S_IFETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready on the final permitted cycle still completes the access
    assign timeout   = mem_phase && !Mem_Ready && (wait_cnt >= CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IFETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        case (state)
            S_IFETCH:   if (Mem_Ready) state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_next = S_EXEC_R;
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            S_EXEC_R:   state_next = funct_ok ? S_R_WB : S_HALT;
            S_EXEC_I:   state_next = S_I_WB;
            S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (Mem_Ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (Mem_Ready) state_next = S_IFETCH;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP:
                        state_next = S_IFETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_HALT;
        endcase
        // Memory wait: count stalled cycles, give up after MAX_WAIT of them
        if (mem_phase && !Mem_Ready) begin
            if (timeout) begin
                state_next = S_HALT;
            end else begin
                state_next    = state;
                wait_cnt_next = wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        PC_WE         = 1'b0;
        IR_WE         = 1'b0;
        RF_WE         = 1'b0;
        MEM_RE        = 1'b0;
        MEM_WE        = 1'b0;
        PC_sel        = 2'd0;
        ALU_Bin_sel   = BSEL_REG;
        ALU_func      = ALU_ADD;
        RF_WrData_sel = 1'b0;
        RF_Dst_sel    = 1'b0;
        Fault         = 1'b0;
        State         = state;
        if (!RST) begin
            case (state)
                S_IFETCH: begin
                    MEM_RE      = 1'b1;
                    ALU_Bin_sel = BSEL_FOUR;
                    IR_WE       = Mem_Ready;
                    PC_WE       = Mem_Ready;
                end
                S_EXEC_R:   ALU_func = r_func;
                S_R_WB: begin
                    RF_WE      = 1'b1;
                    RF_Dst_sel = 1'b1;
                    ALU_func   = r_func;
                end
                S_EXEC_I, S_MEM_ADDR: ALU_Bin_sel = BSEL_IMM;
                S_I_WB:     RF_WE = 1'b1;
                S_MEM_RD:   MEM_RE = 1'b1;
                S_MEM_WB: begin
                    RF_WE         = 1'b1;
                    RF_WrData_sel = 1'b1;
                end
                S_MEM_WR:   MEM_WE = 1'b1;
                S_BRANCH: begin
                    ALU_func = ALU_SUB;
                    PC_sel   = PCSEL_BRANCH;
                    PC_WE    = Zero;
                end
                S_JUMP: begin
                    PC_sel = PCSEL_JUMP;
                    PC_WE  = 1'b1;
                end
                S_HALT:     Fault = 1'b1;
                default:    Fault = 1'b0;
            endcase
        end else begin
            State = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed scenarios plus randomized instruction
// streams, all checked every cycle against an instruction-path reference model.
`timescale 1ns/1ps
module tb_mips_mc_control;

    localparam int unsigned MAX_WAIT = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode, Funct;
    logic       Zero, Mem_Ready;
    logic       PC_WE, IR_WE, RF_WE, MEM_RE, MEM_WE;
    logic [1:0] PC_sel, ALU_Bin_sel;
    logic [3:0] ALU_func;
    logic       RF_WrData_sel, RF_Dst_sel, Fault;
    logic [3:0] State;

    mips_mc_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .Mem_Ready(Mem_Ready), .PC_WE(PC_WE), .IR_WE(IR_WE), .RF_WE(RF_WE),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .PC_sel(PC_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .RF_WrData_sel(RF_WrData_sel), .RF_Dst_sel(RF_Dst_sel),
        .Fault(Fault), .State(State)
    );

    always #10 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: current phase plus the remaining phases of the instruction
    int mst;
    int waitc;
    int path[$];

    function automatic int alu_of(input logic [5:0] f);
        case (f)
            6'h20:   return 0;
            6'h22:   return 1;
            6'h24:   return 2;
            6'h25:   return 3;
            6'h2a:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic bit is_mem_phase(input int s);
        return (s == 0) || (s == 7) || (s == 9);
    endfunction

    task automatic model_reset();
        mst = 0;
        waitc = 0;
        path.delete();
    endtask

    task automatic model_step();
        if (RST) begin
            model_reset();
        end else if (mst != 15) begin
            if (is_mem_phase(mst) && !Mem_Ready) begin
                waitc++;
                if (waitc >= MAX_WAIT) begin
                    mst = 15;
                    waitc = 0;
                end
            end else begin
                waitc = 0;
                if (mst == 0) begin
                    mst = 1;
                end else if (mst == 1) begin
                    path.delete();
                    case (Opcode)
                        6'd0:    path = '{2, 3};
                        6'd8:    path = '{4, 5};
                        6'd35:   path = '{6, 7, 8};
                        6'd43:   path = '{6, 9};
                        6'd4:    path = '{10};
                        6'd2:    path = '{11};
                        default: path = '{15};
                    endcase
                    mst = path.pop_front();
                end else if (mst == 2 && alu_of(Funct) < 0) begin
                    mst = 15;
                end else begin
                    mst = (path.size() != 0) ? path.pop_front() : 0;
                end
            end
        end
    endtask

    function automatic logic [19:0] exp_out();
        logic pc_we, ir_we, rf_we, mem_re, mem_we, wd, dst, flt;
        logic [1:0] psel, bsel;
        logic [3:0] fn, st;
        int a;
        pc_we = 0; ir_we = 0; rf_we = 0; mem_re = 0; mem_we = 0;
        wd = 0; dst = 0; flt = 0; psel = 0; bsel = 0; fn = 0; st = 0;
        a = alu_of(Funct);
        if (!RST) begin
            st = 4'(mst);
            case (mst)
                0:  begin mem_re = 1; bsel = 2; ir_we = Mem_Ready; pc_we = Mem_Ready; end
                2:  fn = (a < 0) ? 4'd0 : 4'(a);
                3:  begin rf_we = 1; dst = 1; fn = (a < 0) ? 4'd0 : 4'(a); end
                4, 6: bsel = 1;
                5:  rf_we = 1;
                7:  mem_re = 1;
                8:  begin rf_we = 1; wd = 1; end
                9:  mem_we = 1;
                10: begin fn = 1; psel = 1; pc_we = Zero; end
                11: begin psel = 2; pc_we = 1; end
                15: flt = 1;
                default: ;
            endcase
        end
        return {pc_we, ir_we, rf_we, mem_re, mem_we, psel, bsel, fn, wd, dst, flt, st};
    endfunction

    wire [19:0] dut_vec = {PC_WE, IR_WE, RF_WE, MEM_RE, MEM_WE, PC_sel, ALU_Bin_sel,
                           ALU_func, RF_WrData_sel, RF_Dst_sel, Fault, State};

    // Single per-cycle comparison of every DUT output against the model
    always @(negedge CLK) check("cycle_outputs", 32'(dut_vec), 32'(exp_out()));

    task automatic tick();
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic set_rst(input logic v);
        RST = v;
        if (v) model_reset();
    endtask

    int seq_r[5] = '{0, 1, 2, 3, 0};
    int cnt_a, cnt_b;
    int halt_cycles;

    initial begin
        Opcode = 6'd0; Funct = 6'h20; Zero = 1'b0; Mem_Ready = 1'b1;
        set_rst(1'b1);
        tick(); tick();
        #1;
        check("reset_state", 32'(State), 32'd0);
        check("reset_all_zero", 32'(dut_vec), 32'd0);

        // R-type add, memory always ready
        set_rst(1'b0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            check("r_state", 32'(State), 32'(seq_r[i]));
            check("model_r_state", 32'(mst), 32'(seq_r[i]));
            if (i < 4) begin
                cnt_a += int'(IR_WE & PC_WE);
                cnt_b += int'(RF_WE);
            end
            if (i == 3) check("r_wb_dst_func", 32'({RF_Dst_sel, RF_WrData_sel, ALU_func}), 32'({1'b1, 1'b0, 4'd0}));
        end
        check("r_fetch_pulses", 32'(cnt_a), 32'd1);
        check("r_rf_we_pulses", 32'(cnt_b), 32'd1);

        // lw with three stalled cycles in MEM_RD
        Opcode = 6'b100011;
        tick(); tick(); tick();
        Mem_Ready = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) Mem_Ready = 1'b1;
            #1;
            check("lw_rd_state", 32'(State), 32'd7);
            cnt_a += int'(MEM_RE);
            tick();
        end
        check("lw_re_cycles", 32'(cnt_a), 32'd4);
        #1;
        check("lw_wb", 32'({State, RF_WE, RF_WrData_sel, RF_Dst_sel}), 32'({4'd8, 1'b1, 1'b1, 1'b0}));
        tick(); #1;
        check("lw_back_to_fetch", 32'(State), 32'd0);

        // beq taken then not taken
        Opcode = 6'b000100; Zero = 1'b1;
        tick(); tick(); #1;
        check("beq_taken", 32'({State, PC_WE, PC_sel}), 32'({4'd10, 1'b1, 2'd1}));
        tick(); #1;
        check("beq_taken_ret", 32'(State), 32'd0);
        Zero = 1'b0;
        tick(); tick(); #1;
        check("beq_not_taken", 32'({State, PC_WE, PC_sel}), 32'({4'd10, 1'b0, 2'd1}));
        tick(); #1;
        check("beq_nt_ret", 32'(State), 32'd0);

        // illegal opcode halts until reset
        Opcode = 6'b111111;
        tick(); tick(); #1;
        check("illegal_halt", 32'({State, Fault}), 32'({4'd15, 1'b1}));
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            Mem_Ready = 1'($urandom_range(0, 1));
            #1;
            cnt_a += int'(PC_WE | IR_WE | RF_WE | MEM_RE | MEM_WE);
            tick();
        end
        check("halt_no_strobes", 32'(cnt_a), 32'd0);
        check("halt_sticky", 32'(State), 32'd15);
        set_rst(1'b1); #1;
        check("halt_reset", 32'({State, Fault}), 32'({4'd0, 1'b0}));
        tick(); set_rst(1'b0);

        // fetch timeout after MAX_WAIT stalled cycles
        Opcode = 6'd0; Funct = 6'h22; Mem_Ready = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            cnt_a += int'(IR_WE);
            tick();
        end
        #1;
        check("timeout_halt", 32'({State, Fault}), 32'({4'd15, 1'b1}));
        check("timeout_no_ir_we", 32'(cnt_a), 32'd0);
        set_rst(1'b1); tick(); set_rst(1'b0);
        Mem_Ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) Mem_Ready = 1'b1;
            #1;
            if (k == 3) check("last_cycle_ready_ir_we", 32'(IR_WE), 32'd1);
            tick();
        end
        #1;
        check("last_cycle_ready_decode", 32'(State), 32'd1);

        // sw aborted by asynchronous reset inside MEM_WR
        set_rst(1'b1); tick(); set_rst(1'b0);
        Opcode = 6'b101011; Mem_Ready = 1'b1;
        tick(); tick(); tick();
        Mem_Ready = 1'b0;
        #1;
        check("sw_mem_we", 32'({State, MEM_WE}), 32'({4'd9, 1'b1}));
        #1;
        set_rst(1'b1);
        #1;
        check("sw_async_abort", 32'({State, MEM_WE, MEM_RE}), 32'({4'd0, 1'b0, 1'b0}));
        tick(); set_rst(1'b0); Mem_Ready = 1'b1;
        #1;
        check("sw_restart", 32'({State, MEM_RE}), 32'({4'd0, 1'b1}));

        // randomized instruction stream
        halt_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mst == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 9: Opcode = 6'd0;
                    2:       Opcode = 6'd8;
                    3:       Opcode = 6'd35;
                    4:       Opcode = 6'd43;
                    5:       Opcode = 6'd4;
                    6:       Opcode = 6'd2;
                    default: Opcode = 6'($urandom_range(0, 63));
                endcase
                case ($urandom_range(0, 7))
                    0:       Funct = 6'h20;
                    1:       Funct = 6'h22;
                    2:       Funct = 6'h24;
                    3:       Funct = 6'h25;
                    4, 5:    Funct = 6'h2a;
                    default: Funct = 6'($urandom_range(0, 63));
                endcase
            end
            Zero = 1'($urandom_range(0, 1));
            Mem_Ready = ($urandom_range(0, 3) != 0);
            if (mst == 15) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 299) == 0) begin
                set_rst(1'b1);
                halt_cycles = 0;
                tick();
                set_rst(1'b0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
